load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum BUSY cycles to wait for bus_ack before aborting (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port MemRead, input, 1, core requests a load.
REQ-005 SHALL have port MemWrite, input, 1, core requests a store.
REQ-006 SHALL have port funct3, input, 3, access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-007 SHALL have port ALUResult, input, 32, byte address.
REQ-008 SHALL have port WriteData, input, 32, store data (low bits significant).
REQ-009 SHALL have port ReadData, output, 32, aligned and extended load result for the writeback mux.
REQ-010 SHALL have port Stall, output, 1, core holds PC and pipeline state while high.
REQ-011 SHALL have port AccessErr, output, 1, one-cycle pulse on misalignment, illegal funct3 or timeout.
REQ-012 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32, bus_wdata out 32, bus_be out 4, bus_ack in 1 and bus_rdata in 32, forming the data-memory bus.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 In IDLE with MemRead or MemWrite high and a legal, aligned access, the unit SHALL latch address, funct3, store data and direction, then enter BUSY.
REQ-015 When both MemRead and MemWrite are high, the access SHALL be treated as a store.
REQ-016 Alignment: lw/sw SHALL need addr[1:0]=00; lh/lhu/sh SHALL need addr[0]=0; byte accesses SHALL always be aligned.
REQ-017 Misaligned access or funct3 in {011,110,111} SHALL start no bus transaction, SHALL pulse AccessErr for the request cycle, SHALL keep Stall=0, SHALL drive ReadData=0 and SHALL stay in IDLE.
REQ-018 Stall SHALL be 1 combinationally in IDLE with a legal request, and 1 throughout BUSY.
REQ-019 Stall SHALL be 0 in DONE.
REQ-020 In BUSY, bus_req SHALL be 1, bus_addr SHALL be {addr[31:2],2'b00}, and bus_we SHALL equal the latched direction.
REQ-021 Outside BUSY, bus_req and bus_we SHALL be 0.
REQ-022 bus_be: sb SHALL give 4'b0001<<addr[1:0]; sh SHALL give 4'b0011<<{addr[1],1'b0}; sw SHALL give 4'b1111; every load SHALL give 4'b1111.
REQ-023 bus_wdata: sb SHALL give {4{WriteData[7:0]}}; sh SHALL give {2{WriteData[15:0]}}; sw SHALL give WriteData.
REQ-024 bus_ack in BUSY SHALL register bus_rdata (loads) and move the FSM to DONE; bus_ack outside BUSY SHALL be ignored.
REQ-025 In DONE, ReadData SHALL be the latched word shifted right by addr[1:0]*8, then sign-extended (lb, lh) or zero-extended (lbu, lhu) from 8/16 bits; lw SHALL return the full word; stores SHALL give ReadData=0.
REQ-026 DONE SHALL last exactly one cycle, SHALL return to IDLE, and SHALL ignore MemRead/MemWrite during that cycle.
REQ-027 Latency: request in cycle N with ack in N+1 SHALL give Stall high in N and N+1 and ReadData valid in N+2; each extra wait cycle SHALL add one cycle.
REQ-028 A down-counter SHALL load TIMEOUT on entry to BUSY; if it reaches 0 without ack, the unit SHALL pulse AccessErr, deassert bus_req, and go to DONE with ReadData=0.
REQ-029 ReadData SHALL be 0 in IDLE and BUSY.

Reset
REQ-030 reset high SHALL immediately force the IDLE state, bus_req=0, bus_we=0, Stall=0, AccessErr=0, ReadData=0, bus_addr=0, bus_wdata=0, bus_be=0, and the counter to 0, including mid-transaction; the aborted transaction SHALL NOT be retried.

Verification
REQ-031 The bench SHALL cover: lb at 0x1003 with bus_rdata=0x80FF_1234 acked on the first BUSY cycle -> ReadData=0xFFFF_FF80 in cycle N+2, Stall high for 2 cycles.
REQ-032 The bench SHALL cover: sh of WriteData=0x0000_ABCD at 0x2002 -> bus_be=1100, bus_wdata=0xABCD_ABCD, bus_addr=0x2000, bus_we=1.
REQ-033 The bench SHALL cover: lw at 0x3001 -> AccessErr=1 for one cycle, bus_req stays 0, Stall=0.
REQ-034 The bench SHALL cover: lhu at 0x4002, bus_rdata=0xF00D_0000, ack after 3 wait cycles -> ReadData=0x0000_F00D, Stall high for 5 cycles.
REQ-035 The bench SHALL cover: TIMEOUT=4 with no ack -> bus_req high for 4 cycles, AccessErr pulse, ReadData=0, FSM returns to IDLE.
REQ-036 The bench SHALL cover: reset asserted during BUSY -> bus_req=0 and Stall=0 before the next clock edge, and a late bus_ack is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the core's MemRead/MemWrite requests onto a simple req/ack
//   data-memory bus. A legal, aligned request is captured in IDLE, driven on
//   the bus in BUSY until bus_ack (or until the wait budget TIMEOUT runs out),
//   and the aligned, extended load result is presented for one DONE cycle.
//
//   Ports
//     clk, reset            : clock, asynchronous active-high reset
//     MemRead, MemWrite     : core load/store request (both high = store)
//     funct3                : access size/sign (lb, lh, lw, lbu, lhu)
//     ALUResult             : byte address
//     WriteData             : store data, low bits significant
//     ReadData              : formatted load result, non-zero only in DONE
//     Stall                 : core hold request
//     AccessErr             : one-cycle error pulse (misalign, bad funct3, timeout)
//     bus_req/we/addr/wdata/be, bus_ack, bus_rdata : data-memory bus
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  // Access legality: funct3 must name a real access and the address must be
  // naturally aligned for its size.
  function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      3'b000, 3'b100: ok = 1'b1;
      3'b001, 3'b101: ok = ~off[0];
      3'b010:         ok = (off == 2'b00);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the byte enables pick the lane.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b100:  r = {24'h000000, s[7:0]};
      3'b101:  r = {16'h0000, s[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  state_t      state_r;
  logic [1:0]  off_r;
  logic [2:0]  f3_r;
  logic        we_r;
  logic [7:0]  cnt_r;
  logic [31:0] rdata_r;
  logic        tmo_err_r;
  logic        bus_req_r;
  logic        bus_we_r;
  logic [31:0] bus_addr_r;
  logic [31:0] bus_wdata_r;
  logic [3:0]  bus_be_r;

  logic        req_s;
  logic        legal_s;
  logic        start_s;
  logic        reject_s;

  // Classify the request presented while idle; nothing is accepted during reset.
  always_comb begin
    req_s    = MemRead | MemWrite;
    legal_s  = access_legal(funct3, ALUResult[1:0]);
    start_s  = 1'b0;
    reject_s = 1'b0;
    if (!reset && (state_r == IDLE) && req_s) begin
      start_s  = legal_s;
      reject_s = ~legal_s;
    end else begin
      start_s  = 1'b0;
      reject_s = 1'b0;
    end
  end

  // Sequencer: capture the request, run the bus handshake with its wait
  // budget, and hold the formatted result for the single DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      off_r       <= 2'b00;
      f3_r        <= 3'b000;
      we_r        <= 1'b0;
      cnt_r       <= 8'd0;
      rdata_r     <= 32'd0;
      tmo_err_r   <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 32'd0;
      bus_be_r    <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          rdata_r   <= 32'd0;
          tmo_err_r <= 1'b0;
          if (start_s) begin
            state_r     <= BUSY;
            off_r       <= ALUResult[1:0];
            f3_r        <= funct3;
            we_r        <= MemWrite;
            cnt_r       <= TIMEOUT_C;
            bus_req_r   <= 1'b1;
            bus_we_r    <= MemWrite;
            bus_addr_r  <= {ALUResult[31:2], 2'b00};
            bus_be_r    <= MemWrite ? store_be(funct3[1:0], ALUResult[1:0]) : 4'b1111;
            bus_wdata_r <= MemWrite ? store_wdata(funct3[1:0], WriteData) : 32'd0;
          end
        end
        BUSY: begin
          // An ack in the last budget cycle still wins over the timeout.
          if (bus_ack || (cnt_r <= 8'd1)) begin
            state_r     <= DONE;
            cnt_r       <= 8'd0;
            tmo_err_r   <= ~bus_ack;
            rdata_r     <= (bus_ack && !we_r) ? load_align(f3_r, off_r, bus_rdata) : 32'd0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_wdata_r <= 32'd0;
            bus_be_r    <= 4'd0;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          rdata_r   <= 32'd0;
          tmo_err_r <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= 8'd0;
          rdata_r     <= 32'd0;
          tmo_err_r   <= 1'b0;
          bus_req_r   <= 1'b0;
          bus_we_r    <= 1'b0;
          bus_addr_r  <= 32'd0;
          bus_wdata_r <= 32'd0;
          bus_be_r    <= 4'd0;
        end
      endcase
    end
  end

  // Stall covers the accepting cycle as well, so the core never advances
  // past a request that has been taken.
  assign Stall     = ~reset & (start_s | (state_r == BUSY));
  assign AccessErr = reject_s | tmo_err_r;
  assign ReadData  = rdata_r;
  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign bus_be    = bus_be_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (instantiated with TIMEOUT=4).
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AccessErr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .AccessErr(AccessErr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference model (arithmetic on the access rules) ----------------
  function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 32'd2) == 32'd0;
      3'd2:       return (a % 32'd4) == 32'd0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    logic [31:0] b;
    logic [31:0] h;
    v = w / (32'd1 << ((a % 32'd4) * 32'd8));
    b = v % 32'd256;
    h = v % 32'd65536;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] m;
    if (!st) return 4'b1111;
    case (f3)
      3'd0:    m = 32'd1 << (a % 32'd4);
      3'd1:    m = 32'd3 << (a % 32'd4);
      default: m = 32'd15;
    endcase
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    return (wd % 32'd256) * 32'h0101_0101;
      3'd1:    return (wd % 32'd65536) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // One complete transaction; entered and left just after a rising edge.
  task automatic run_txn(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                         input int waits, input logic legal, input logic [31:0] e_baddr,
                         input logic [3:0] e_be, input logic [31:0] e_wdata, input logic [31:0] e_rd);
    int  busy_n;
    int  stall_n;
    int  e_busy;
    bit  tmo;
    bit  fin;
    tmo    = (waits >= TMO);
    e_busy = tmo ? TMO : waits + 1;
    MemRead   = rd;
    MemWrite  = wr;
    funct3    = f3;
    ALUResult = addr;
    WriteData = wd;
    bus_ack   = 1'b0;
    @(negedge clk);
    chk1({tag, ".req_stall"}, Stall, legal);
    chk1({tag, ".req_err"}, AccessErr, ~legal);
    chk1({tag, ".req_busreq"}, bus_req, 1'b0);
    chk({tag, ".req_rdata"}, ReadData, 32'd0);
    if (!legal) begin
      @(posedge clk); #1;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      @(negedge clk);
      chk1({tag, ".rej_busreq"}, bus_req, 1'b0);
      chk1({tag, ".rej_stall"}, Stall, 1'b0);
      chk1({tag, ".rej_err"}, AccessErr, 1'b0);
      @(posedge clk); #1;
      return;
    end
    stall_n = 1;
    busy_n  = 0;
    fin     = 1'b0;
    for (int i = 0; i < TMO && !fin; i++) begin
      @(posedge clk); #1;
      bus_ack   = (i == waits);
      bus_rdata = (i == waits) ? rdata : $urandom;
      @(negedge clk);
      busy_n++;
      if (Stall) stall_n++;
      chk1({tag, ".busy_req"}, bus_req, 1'b1);
      chk1({tag, ".busy_we"}, bus_we, wr);
      chk({tag, ".busy_addr"}, bus_addr, e_baddr);
      chk({tag, ".busy_be"}, 32'(bus_be), 32'(e_be));
      if (wr) chk({tag, ".busy_wdata"}, bus_wdata, e_wdata);
      chk({tag, ".busy_rdata"}, ReadData, 32'd0);
      chk1({tag, ".busy_err"}, AccessErr, 1'b0);
      if (i == waits) fin = 1'b1;
    end
    chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(e_busy));
    chk({tag, ".stall_cycles"}, 32'(stall_n), 32'(e_busy + 1));
    // DONE: requests still asserted and a stray ack must both be ignored.
    @(posedge clk); #1;
    bus_ack   = 1'($urandom);
    bus_rdata = $urandom;
    @(negedge clk);
    chk1({tag, ".done_stall"}, Stall, 1'b0);
    chk1({tag, ".done_req"}, bus_req, 1'b0);
    chk1({tag, ".done_we"}, bus_we, 1'b0);
    chk({tag, ".done_rdata"}, ReadData, e_rd);
    chk1({tag, ".done_err"}, AccessErr, tmo);
    @(posedge clk); #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    bus_ack  = 1'b0;
    @(negedge clk);
    chk1({tag, ".idle_req"}, bus_req, 1'b0);
    chk1({tag, ".idle_stall"}, Stall, 1'b0);
    chk({tag, ".idle_rdata"}, ReadData, 32'd0);
    chk1({tag, ".idle_err"}, AccessErr, 1'b0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic        legal;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdv;
  } vec_t;

  vec_t        vecs[13];
  logic        r_rd, r_wr, r_lg;
  logic [2:0]  r_f3;
  logic [31:0] r_a, r_wd, r_dat, r_erd;
  int          r_w;

  initial begin
    //            rd    wr    f3      addr          wd            rdata         w  legal baddr         be       wdata         ReadData
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 1'b1, 32'h0000_1000, 4'b1111, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        0, 1'b1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,        0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0,        32'hF00D_0000, 3, 1'b1, 32'h0000_4000, 4'b1111, 32'h0,        32'h0000_F00D};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0,        32'h1234_5678, 4, 1'b1, 32'h0000_5000, 4'b1111, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h0000_6001, 32'h0000_0077, 32'h0,        1, 1'b1, 32'h0000_6000, 4'b0010, 32'h7777_7777, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h0000_7000, 32'h0,        32'h1234_8001, 2, 1'b1, 32'h0000_7000, 4'b1111, 32'h0,        32'hFFFF_8001};
    vecs[7]  = '{1'b1, 1'b0, 3'b100, 32'h0000_8002, 32'h0,        32'h00AB_0000, 0, 1'b1, 32'h0000_8000, 4'b1111, 32'h0,        32'h0000_00AB};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_9000, 32'hDEAD_BEEF, 32'h0,        1, 1'b1, 32'h0000_9000, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h0000_A000, 32'h0,        32'h0,        0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h0000_B004, 32'h0123_4567, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_B004, 4'b1111, 32'h0123_4567, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h0000_C001, 32'h0,        32'h0,        0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 3'b000, 32'h0000_D002, 32'h0,        32'h0055_0000, 0, 1'b1, 32'h0000_D000, 4'b1111, 32'h0,        32'h0000_0055};

    // Reset state, with a request held high to show it is not accepted.
    reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b011;
    ALUResult = 32'h0000_0001; WriteData = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    chk1("rst.stall", Stall, 1'b0);
    chk1("rst.err", AccessErr, 1'b0);
    chk1("rst.req", bus_req, 1'b0);
    chk1("rst.we", bus_we, 1'b0);
    chk("rst.rdata", ReadData, 32'd0);
    chk("rst.addr", bus_addr, 32'd0);
    chk("rst.wdata", bus_wdata, 32'd0);
    chk("rst.be", 32'(bus_be), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; MemRead = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 13; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].rd, vecs[v].wr, vecs[v].f3, vecs[v].addr,
              vecs[v].wd, vecs[v].rdata, vecs[v].waits, vecs[v].legal, vecs[v].baddr,
              vecs[v].be, vecs[v].wdata, vecs[v].rdv);
    end

    // Reset in the middle of BUSY, then a late ack that must be ignored.
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h0000_E000;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("midrst.busy_req", bus_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("midrst.req", bus_req, 1'b0);
    chk1("midrst.stall", Stall, 1'b0);
    chk1("midrst.we", bus_we, 1'b0);
    chk("midrst.addr", bus_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; MemRead = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1($sformatf("midrst.after%0d_req", c), bus_req, 1'b0);
      chk1($sformatf("midrst.after%0d_stall", c), Stall, 1'b0);
      chk($sformatf("midrst.after%0d_rdata", c), ReadData, 32'd0);
      chk1($sformatf("midrst.after%0d_err", c), AccessErr, 1'b0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end

    // Randomised transactions checked against the reference model.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    begin r_rd = 1'b1; r_wr = 1'b0; end
        2:       begin r_rd = 1'b0; r_wr = 1'b1; end
        default: begin r_rd = 1'b1; r_wr = 1'b1; end
      endcase
      r_f3 = 3'($urandom_range(0, 7));
      if (r_wr && (r_f3 == 3'd4 || r_f3 == 3'd5)) r_f3 = r_f3 - 3'd4;
      r_a = $urandom;
      if ($urandom_range(0, 2) != 0) r_a = r_a & 32'hFFFF_FFFC;
      r_wd  = $urandom;
      r_dat = $urandom;
      r_w   = $urandom_range(0, 5);
      r_lg  = m_legal(r_f3, r_a);
      r_erd = (r_wr || r_w >= TMO) ? 32'd0 : m_load(r_f3, r_a, r_dat);
      run_txn($sformatf("rnd%0d", k), r_rd, r_wr, r_f3, r_a, r_wd, r_dat, r_w, r_lg,
              r_a & 32'hFFFF_FFFC, m_be(r_wr, r_f3, r_a), m_wdata(r_f3, r_wd), r_erd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
